// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the byte PC, reads the single-cycle imem and
// feeds decode through a 2-entry buffer with redirect and halt control.
module imem_fetch_ctrl #(
    parameter int unsigned    n        = 32,
    parameter int unsigned    r        = 6,
    parameter logic [n-1:0]   RESET_PC = '0
) (
    input  logic           clk,
    input  logic           reset,
    output logic [r-1:0]   imem_addr,
    input  logic [n-1:0]   imem_read_dat,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [n-1:0]   out_instr,
    output logic [n-1:0]   out_pc,
    input  logic           redirect,
    input  logic [n-1:0]   redirect_pc,
    input  logic           halt,
    output logic           halted
);

    localparam logic [n-1:0] PC_INIT  = {RESET_PC[n-1:2], 2'b00};
    localparam logic [n-1:0] PC_STEP  = n'(4);
    localparam logic [n-1:0] PC_ALIGN = ~n'(3);

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    state_t         state;
    logic [n-1:0]   pc;

    // Buffer head (presented to decode) and tail (second slot)
    logic           h_v;
    logic [n-1:0]   h_instr;
    logic [n-1:0]   h_pc;
    logic           t_v;
    logic [n-1:0]   t_instr;
    logic [n-1:0]   t_pc;

    logic           deq;
    logic           enq;

    assign imem_addr = pc[r+1:2];
    assign out_valid = h_v;
    assign out_instr = h_instr;
    assign out_pc    = h_pc;
    assign halted    = (state == HALTED);

    assign deq = h_v & out_ready;
    // Tail free means fewer than two entries held
    assign enq = (state == RUN) & ~redirect & ~halt & (~t_v | deq);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= RUN;
            pc      <= PC_INIT;
            h_v     <= 1'b0;
            h_instr <= '0;
            h_pc    <= '0;
            t_v     <= 1'b0;
            t_instr <= '0;
            t_pc    <= '0;
        end else begin
            if (redirect) begin
                state <= RUN;
            end else if (halt) begin
                state <= HALTED;
            end

            if (redirect) begin
                pc <= redirect_pc & PC_ALIGN;
            end else if (enq) begin
                pc <= pc + PC_STEP;
            end

            if (redirect) begin
                h_v     <= 1'b0;
                h_instr <= '0;
                h_pc    <= '0;
                t_v     <= 1'b0;
            end else if (deq) begin
                if (t_v) begin
                    // Tail advances to head; new word (if any) refills the tail
                    h_instr <= t_instr;
                    h_pc    <= t_pc;
                    if (enq) begin
                        t_instr <= imem_read_dat;
                        t_pc    <= pc;
                    end else begin
                        t_v <= 1'b0;
                    end
                end else if (enq) begin
                    h_instr <= imem_read_dat;
                    h_pc    <= pc;
                end else begin
                    h_v     <= 1'b0;
                    h_instr <= '0;
                    h_pc    <= '0;
                end
            end else if (enq) begin
                if (!h_v) begin
                    h_v     <= 1'b1;
                    h_instr <= imem_read_dat;
                    h_pc    <= pc;
                end else begin
                    t_v     <= 1'b1;
                    t_instr <= imem_read_dat;
                    t_pc    <= pc;
                end
            end
        end
    end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Scoreboard bench for imem_fetch_ctrl: the expected fetch stream is queued on
// every (re)start and compared against each instruction decode accepts.
module tb_imem_fetch_ctrl;

    localparam int unsigned N = 32;
    localparam int unsigned R = 6;

    typedef struct packed {
        logic [N-1:0] pc;
        logic [N-1:0] instr;
    } ent_t;

    logic           clk;
    logic           reset;
    logic [R-1:0]   imem_addr;
    logic [N-1:0]   imem_read_dat;
    logic           out_valid;
    logic           out_ready;
    logic [N-1:0]   out_instr;
    logic [N-1:0]   out_pc;
    logic           redirect;
    logic [N-1:0]   redirect_pc;
    logic           halt;
    logic           halted;

    logic [N-1:0]   mem [64];
    ent_t           sb [$];
    int             errors;
    int             checks;
    int             pops;

    imem_fetch_ctrl #(.n(N), .r(R), .RESET_PC(32'h0)) dut (
        .clk           (clk),
        .reset         (reset),
        .imem_addr     (imem_addr),
        .imem_read_dat (imem_read_dat),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_instr     (out_instr),
        .out_pc        (out_pc),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .halt          (halt),
        .halted        (halted)
    );

    assign imem_read_dat = mem[imem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_instr(input logic [31:0] p);
        return 32'h100 + {26'b0, p[7:2]};
    endfunction

    // Expected stream after a (re)start at byte address start
    task automatic sb_restart(input logic [31:0] start);
        logic [31:0] p;
        sb.delete();
        for (int i = 0; i < 80; i++) begin
            p = start + 32'(4 * i);
            sb.push_back('{pc: p, instr: exp_instr(p)});
        end
    endtask

    // Output monitor: every accepted instruction must match the scoreboard head
    always @(negedge clk) begin
        if (!reset) begin
            if (out_valid) begin
                if (sb.size() == 0) begin
                    check("sb_empty", 32'd1, 32'd0);
                end else if (out_ready) begin
                    check("deq_pc", out_pc, sb[0].pc);
                    check("deq_instr", out_instr, sb[0].instr);
                    void'(sb.pop_front());
                    pops++;
                end else begin
                    check("hold_pc", out_pc, sb[0].pc);
                    check("hold_instr", out_instr, sb[0].instr);
                end
            end else begin
                check("idle_pc", out_pc, 32'd0);
                check("idle_instr", out_instr, 32'd0);
            end
        end
    end

    initial begin
        int p0;
        logic [R-1:0] a0;
        errors      = 0;
        checks      = 0;
        pops        = 0;
        reset       = 1'b1;
        out_ready   = 1'b1;
        redirect    = 1'b0;
        redirect_pc = '0;
        halt        = 1'b0;
        for (int k = 0; k < 64; k++) mem[k] = 32'h100 + 32'(k);
        sb_restart(32'h0);

        #2;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_instr", out_instr, 32'd0);
        check("rst_pc", out_pc, 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_addr", 32'(imem_addr), 32'd0);

        // Reset release, streaming with out_ready high
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("t1_valid_c0", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("t1_valid_c1", 32'(out_valid), 32'd1);
        repeat (6) @(posedge clk);
        #1;

        // Back-pressure: buffer saturates at two entries
        reset = 1'b1;
        sb_restart(32'h0);
        out_ready = 1'b0;
        #1 reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("t2_addr", 32'(imem_addr), 32'd2);
        check("t2_pc", out_pc, 32'h0);
        check("t2_instr", out_instr, 32'h100);
        p0 = pops;
        out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("t2_drain", 32'(pops - p0), 32'd6);

        // Redirect with a full buffer to an unaligned target
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        redirect    = 1'b1;
        redirect_pc = 32'h43;
        @(posedge clk);
        #1 redirect = 1'b0;
        sb_restart(32'h40);
        @(negedge clk);
        check("t3_bubble", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        check("t3_valid", 32'(out_valid), 32'd1);
        check("t3_pc", out_pc, 32'h40);
        check("t3_instr", out_instr, 32'h110);

        // Halt with two entries held: they drain, then fetch stays frozen
        @(posedge clk);
        #1 halt = 1'b1;
        @(posedge clk);
        #1 halt = 1'b0;
        check("t4_halted", 32'(halted), 32'd1);
        a0 = imem_addr;
        check("t4_addr", 32'(a0), 32'd18);
        p0 = pops;
        out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("t4_drained", 32'(pops - p0), 32'd2);
        check("t4_idle", 32'(out_valid), 32'd0);
        check("t4_frozen", 32'(imem_addr), 32'(a0));
        check("t4_still_halted", 32'(halted), 32'd1);
        redirect    = 1'b1;
        redirect_pc = 32'h0;
        @(posedge clk);
        #1 redirect = 1'b0;
        sb_restart(32'h0);
        check("t4_resumed", 32'(halted), 32'd0);
        p0 = pops;
        repeat (4) @(posedge clk);
        #1;
        check("t4_refetch", 32'(pops - p0), 32'd3);

        // imem word address wrap at the top of the array
        redirect    = 1'b1;
        redirect_pc = 32'hF8;
        @(posedge clk);
        #1 redirect = 1'b0;
        sb_restart(32'hF8);
        check("t5_addr62", 32'(imem_addr), 32'd62);
        @(posedge clk);
        #1 check("t5_addr63", 32'(imem_addr), 32'd63);
        @(posedge clk);
        #1 check("t5_addr_wrap", 32'(imem_addr), 32'd0);
        @(posedge clk);
        #1;
        check("t5_pc", out_pc, 32'h100);
        check("t5_instr", out_instr, 32'h100);
        // Redirect and halt together: redirect wins
        redirect    = 1'b1;
        halt        = 1'b1;
        redirect_pc = 32'h20;
        @(posedge clk);
        #1;
        redirect = 1'b0;
        halt     = 1'b0;
        sb_restart(32'h20);
        check("t5_not_halted", 32'(halted), 32'd0);
        repeat (3) @(posedge clk);
        #1 check("t5_running", 32'(out_valid), 32'd1);

        // Asynchronous reset between edges
        #3 reset = 1'b1;
        #1;
        check("t6_valid", 32'(out_valid), 32'd0);
        check("t6_addr", 32'(imem_addr), 32'd0);
        check("t6_pc", out_pc, 32'd0);
        check("t6_halted", 32'(halted), 32'd0);
        sb_restart(32'h0);
        @(negedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        check("t6_valid_c1", 32'(out_valid), 32'd1);
        check("t6_pc_c1", out_pc, 32'h0);
        repeat (4) @(posedge clk);
        #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
